// File: rtl/ff_pipe_arbiter.sv
// Round-robin, burst-bounded, credit-gated arbiter driving the cs input of a shared
// two-stage register pipeline, with a matching valid/tag shift register for ns.
module ff_pipe_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned BURST   = 4,
    parameter int unsigned CREDITS = 3,
    localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             credit_return,
    output logic [WIDTH-1:0] pipe_cs,
    output logic             out_valid,
    output logic             out_tag,
    output logic [CW-1:0]    credits
);

    localparam int unsigned BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic [WIDTH-1:0] pipe_cs_q, pipe_cs_d;
    logic [2:0]       vld_q;
    logic [2:0]       tag_q;
    logic             gnt0, gnt1, issue;

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        burst_d = burst_q;
        // With no credits everything holds: no grant, no state or burst change.
        if (credits_q != '0) begin
            unique case (state_q)
                IDLE: begin
                    if (req0_valid && (!req1_valid || last_q)) begin
                        gnt0 = 1'b1; state_d = SERVE0; burst_d = BURST_ONE;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1; state_d = SERVE1; burst_d = BURST_ONE;
                    end
                end
                SERVE0: begin
                    if (req0_valid && burst_q < BURST_MAX) begin
                        gnt0 = 1'b1; burst_d = burst_q + BURST_ONE;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1; state_d = SERVE1; burst_d = BURST_ONE;
                    end else if (req0_valid) begin
                        gnt0 = 1'b1; burst_d = BURST_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SERVE1: begin
                    if (req1_valid && burst_q < BURST_MAX) begin
                        gnt1 = 1'b1; burst_d = burst_q + BURST_ONE;
                    end else if (req0_valid) begin
                        gnt0 = 1'b1; state_d = SERVE0; burst_d = BURST_ONE;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1; burst_d = BURST_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        issue     = gnt0 | gnt1;
        last_d    = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);
        pipe_cs_d = gnt0 ? req0_data : (gnt1 ? req1_data : '0);
        credits_d = credits_q;
        if (issue && !credit_return) begin
            credits_d = credits_q - CW'(1);
        end else if (!issue && credit_return && credits_q != CRED_MAX) begin
            credits_d = credits_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            burst_q   <= '0;
            credits_q <= CRED_MAX;
            pipe_cs_q <= '0;
            vld_q     <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            credits_q <= credits_d;
            pipe_cs_q <= pipe_cs_d;
            vld_q     <= {vld_q[1:0], issue};
            tag_q     <= {tag_q[1:0], gnt1};
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign pipe_cs    = pipe_cs_q;
    assign out_valid  = vld_q[2];
    assign out_tag    = tag_q[2];
    assign credits    = credits_q;

endmodule

// File: tb/tb_ff_pipe_arbiter.sv
// Directed bench for ff_pipe_arbiter; models the external cs -> stage -> ns registers.
module tb_ff_pipe_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req0_valid, req1_valid, credit_return;
    logic [3:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [3:0] pipe_cs;
    logic       out_valid, out_tag;
    logic [1:0] credits;
    logic [3:0] stage_q, ns_q;

    int total = 0;
    int bad   = 0;

    ff_pipe_arbiter #(.WIDTH(4), .BURST(4), .CREDITS(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .credit_return(credit_return), .pipe_cs(pipe_cs),
        .out_valid(out_valid), .out_tag(out_tag), .credits(credits)
    );

    always #5 clock = ~clock;

    // Shared pipeline outside the arbiter: no reset, no enable.
    always_ff @(posedge clock) begin
        stage_q <= pipe_cs;
        ns_q    <= stage_q;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; credit_return = 1'b0;
        req0_data = '0; req1_data = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, "_r0"}, {7'd0, req0_ready}, {7'd0, r0});
        check({tag, "_r1"}, {7'd0, req1_ready}, {7'd0, r1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    order [10];
        logic [3:0] dat;
        order = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

        // Test 1: reset values and a single req0 beat.
        do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_pipe_cs", {4'd0, pipe_cs}, 8'h0);
        check("rst_out_valid", {7'd0, out_valid}, 8'h0);
        check("rst_out_tag", {7'd0, out_tag}, 8'h0);
        check("rst_credits", {6'd0, credits}, 8'd3);
        do_reset();
        req0_valid = 1'b1; req0_data = 4'hA;
        #1;
        check_rdy("t1_grant", 1'b1, 1'b0);
        cyc();
        req0_valid = 1'b0;
        check("t1_pipe_cs", {4'd0, pipe_cs}, 8'hA);
        check("t1_credits", {6'd0, credits}, 8'd2);
        check("t1_ov_e0", {7'd0, out_valid}, 8'h0);
        cyc();
        check("t1_pipe_idle", {4'd0, pipe_cs}, 8'h0);
        check("t1_ov_e1", {7'd0, out_valid}, 8'h0);
        cyc();
        check("t1_ov_e2", {7'd0, out_valid}, 8'h1);
        check("t1_tag_e2", {7'd0, out_tag}, 8'h0);
        check("t1_ns_e2", {4'd0, ns_q}, 8'hA);
        cyc();
        check("t1_ov_e3", {7'd0, out_valid}, 8'h0);
        check("t1_credits_end", {6'd0, credits}, 8'd2);

        // Test 2: both requesters always valid, credit refilled every cycle.
        do_reset();
        req0_valid = 1'b1; req0_data = 4'h3;
        req1_valid = 1'b1; req1_data = 4'hC;
        credit_return = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) check("t2_pipe_cs", {4'd0, pipe_cs}, 8'h0);
            else begin
                dat = (order[i-1] == 0) ? 4'h3 : 4'hC;
                check("t2_pipe_cs", {4'd0, pipe_cs}, {4'd0, dat});
            end
            if (i >= 3) begin
                dat = (order[i-3] == 0) ? 4'h3 : 4'hC;
                check("t2_out_valid", {7'd0, out_valid}, 8'h1);
                check("t2_out_tag", {7'd0, out_tag}, 8'(order[i-3]));
                check("t2_ns", {4'd0, ns_q}, {4'd0, dat});
            end else begin
                check("t2_out_valid", {7'd0, out_valid}, 8'h0);
            end
            check("t2_credits", {6'd0, credits}, 8'd3);
            #1;
            check_rdy("t2_order", order[i] == 0, order[i] == 1);
            cyc();
        end

        // Test 3/4: credit exhaustion, single return, issue+return at one credit.
        do_reset();
        req0_valid = 1'b1; req0_data = 4'h1;
        req1_valid = 1'b1; req1_data = 4'h2;
        #1; check_rdy("t3_c0", 1'b1, 1'b0); cyc();
        check("t3_cr1", {6'd0, credits}, 8'd2);
        #1; check_rdy("t3_c1", 1'b1, 1'b0); cyc();
        check("t3_cr2", {6'd0, credits}, 8'd1);
        #1; check_rdy("t3_c2", 1'b1, 1'b0); cyc();
        check("t3_cr3", {6'd0, credits}, 8'd0);
        #1; check_rdy("t3_c3", 1'b0, 1'b0); cyc();
        check("t3_cr4", {6'd0, credits}, 8'd0);
        credit_return = 1'b1;
        #1; check_rdy("t3_ret_same", 1'b0, 1'b0); cyc();
        credit_return = 1'b0;
        check("t3_cr5", {6'd0, credits}, 8'd1);
        #1; check_rdy("t3_after_ret", 1'b1, 1'b0); cyc();
        check("t3_cr6", {6'd0, credits}, 8'd0);
        credit_return = 1'b1;
        #1; check_rdy("t3_c6", 1'b0, 1'b0); cyc();
        check("t4_cr7", {6'd0, credits}, 8'd1);
        #1; check_rdy("t4_switch", 1'b0, 1'b1); cyc();
        credit_return = 1'b0;
        check("t4_cr_both", {6'd0, credits}, 8'd1);
        #1; check_rdy("t4_again", 1'b0, 1'b1); cyc();
        check("t4_cr_end", {6'd0, credits}, 8'd0);
        #1; check_rdy("t4_empty", 1'b0, 1'b0);

        // Test 5: reset with beats in flight.
        do_reset();
        req0_valid = 1'b1; req0_data = 4'h5;
        cyc();
        req0_data = 4'h6;
        cyc();
        req0_valid = 1'b0;
        check("t5_pipe_cs", {4'd0, pipe_cs}, 8'h6);
        cyc();
        check("t5_ov_before", {7'd0, out_valid}, 8'h1);
        check("t5_ns_before", {4'd0, ns_q}, 8'h5);
        check("t5_cr_before", {6'd0, credits}, 8'd1);
        reset_n = 1'b0;
        #1;
        check("t5_ov_async", {7'd0, out_valid}, 8'h0);
        check("t5_pipe_async", {4'd0, pipe_cs}, 8'h0);
        check("t5_cr_async", {6'd0, credits}, 8'd3);
        cyc(); cyc();
        reset_n = 1'b1;
        credit_return = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_idle_ov", {7'd0, out_valid}, 8'h0);
            check("t5_idle_pipe", {4'd0, pipe_cs}, 8'h0);
            check("t5_idle_cr", {6'd0, credits}, 8'd3);
            check_rdy("t5_idle", 1'b0, 1'b0);
            cyc();
        end
        credit_return = 1'b0;
        req0_valid = 1'b1; req0_data = 4'h9;
        req1_valid = 1'b1; req1_data = 4'h7;
        #1; check_rdy("t5_idle_pick", 1'b1, 1'b0); cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t5_new_pipe", {4'd0, pipe_cs}, 8'h9);
        cyc(); cyc();
        check("t5_new_ov", {7'd0, out_valid}, 8'h1);
        check("t5_new_tag", {7'd0, out_tag}, 8'h0);
        check("t5_new_ns", {4'd0, ns_q}, 8'h9);

        // Test 6: req1 alone keeps its grant past the burst limit.
        do_reset();
        credit_return = 1'b1;
        req1_valid = 1'b1; req1_data = 4'hB;
        for (int i = 0; i < 9; i++) begin
            check("t6_out_valid", {7'd0, out_valid}, (i >= 3) ? 8'h1 : 8'h0);
            if (i >= 3) check("t6_out_tag", {7'd0, out_tag}, 8'h1);
            check("t6_credits", {6'd0, credits}, 8'd3);
            #1;
            check_rdy("t6_solo", 1'b0, 1'b1);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
